motor_dir_ctrl: RTL and testbench

- Two-motor H-bridge direction controller for the rover.
- Takes the obstacle sensors senseA (left) and senseB (right), then synchronises and debounces them.
- Runs a forward / back-up / pivot state machine with enforced dead time, and PWM-gates the result.
- Drives input1..input4 to the H-bridge driver. The seven-segment status display consumes the same four signals plus the raw senseA/senseB.

---
 rtl/motor_dir_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_motor_dir_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_dir_ctrl.sv
// Two-motor H-bridge direction controller.
// Synchronises and debounces two obstacle sensors, sequences forward / back-up / pivot
// with all-off dead time between drive changes, and PWM-gates the drive pattern.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   senseA      left obstacle sensor (async, 1 = obstacle)
//   senseB      right obstacle sensor (async, 1 = obstacle)
//   enable      run request; 0 forces IDLE on the next edge
//   duty        PWM on-time, compared against a free-running counter
//   input1..4   H-bridge inputs (A fwd, A rev, B rev, B fwd), registered
//   dbg_state   registered FSM state (IDLE=0 DEAD=1 FWD=2 REV=3 TURN_L=4 TURN_R=5)
module motor_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned DEADTIME_CYCLES = 10000,
  parameter int unsigned REVERSE_CYCLES  = 50000000,
  parameter int unsigned TURN_CYCLES     = 40000000,
  parameter int unsigned PWM_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             senseA,
  input  logic             senseB,
  input  logic             enable,
  input  logic [PWM_W-1:0] duty,
  output logic             input1,
  output logic             input2,
  output logic             input3,
  output logic             input4,
  output logic [2:0]       dbg_state
);

  localparam int unsigned DebW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CntMax =
      (REVERSE_CYCLES > TURN_CYCLES) ?
      ((REVERSE_CYCLES > DEADTIME_CYCLES) ? REVERSE_CYCLES : DEADTIME_CYCLES) :
      ((TURN_CYCLES > DEADTIME_CYCLES) ? TURN_CYCLES : DEADTIME_CYCLES);
  localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [DebW-1:0] DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEADTIME_CYCLES - 1);
  localparam logic [CntW-1:0] RevLast  = CntW'(REVERSE_CYCLES - 1);
  localparam logic [CntW-1:0] TurnLast = CntW'(TURN_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDead  = 3'd1,
    StFwd   = 3'd2,
    StRev   = 3'd3,
    StTurnL = 3'd4,
    StTurnR = 3'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // Sensor synchronisers and debouncers; bit 0 = senseA (left), bit 1 = senseB (right)
  // ---------------------------------------------------------------------------
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            db_q, db_d;
  logic [1:0][DebW-1:0]  dcnt_q, dcnt_d;

  always_comb begin
    db_d   = db_q;
    dcnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      // Count only while the synchronised level disagrees; any agreement restarts it.
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DebLast) begin
          db_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DebW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dcnt_q  <= '0;
    end else begin
      sync1_q <= {senseB, senseA};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Direction FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  state_e          nxt_q, nxt_d;    // destination once the dead time expires
  state_e          turn_q, turn_d;  // pivot side chosen when the obstacle was seen
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      // Coasting is always safe, so dropping enable skips the dead time.
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StDead;
          nxt_d   = StFwd;
          cnt_d   = '0;
        end
        StDead: begin
          if (cnt_q == DeadLast) begin
            state_d = nxt_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StFwd: begin
          if (|db_q) begin
            state_d = StDead;
            nxt_d   = StRev;
            // Left obstacle (or both) pivots right; right-only pivots left.
            turn_d  = db_q[0] ? StTurnR : StTurnL;
            cnt_d   = '0;
          end
        end
        StRev: begin
          if (cnt_q == RevLast) begin
            state_d = StDead;
            nxt_d   = turn_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StTurnL, StTurnR: begin
          if (cnt_q == TurnLast) begin
            state_d = StDead;
            nxt_d   = StFwd;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drive pattern and PWM gating. The output register is fed from the next state and
  // the next PWM count so pins and dbg_state change on the same edge.
  // ---------------------------------------------------------------------------
  logic [PWM_W-1:0] pcnt_q, pcnt_d;
  logic [3:0]       pat_d, out_d, out_q;

  always_comb begin
    case (state_d)
      StFwd:   pat_d = 4'b1001;
      StRev:   pat_d = 4'b0110;
      StTurnR: pat_d = 4'b1010;
      StTurnL: pat_d = 4'b0101;
      default: pat_d = 4'b0000;
    endcase
    pcnt_d = pcnt_q + PWM_W'(1);
    out_d  = (pcnt_d < duty) ? pat_d : 4'b0000;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      nxt_q   <= StIdle;
      turn_q  <= StIdle;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      out_q   <= out_d;
    end
  end

  assign {input1, input2, input3, input4} = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_dir_ctrl.sv
// Bench for motor_dir_ctrl with small timing parameters. A behavioural model (phase plus
// remaining-time countdown, run-length debounce) is compared against the pins every cycle;
// a table of timed vectors and a few hand sequences pin down the named scenarios.
module tb_motor_dir_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned DT   = 3;
  localparam int unsigned REVC = 10;
  localparam int unsigned TRN  = 8;
  localparam int unsigned PW   = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          senseA, senseB, enable;
  logic [PW-1:0] duty;
  logic          input1, input2, input3, input4;
  logic [2:0]    dbg_state;

  always #5 clock = ~clock;

  motor_dir_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DEADTIME_CYCLES(DT),
    .REVERSE_CYCLES (REVC),
    .TURN_CYCLES    (TRN),
    .PWM_W          (PW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .senseA   (senseA),
    .senseB   (senseB),
    .enable   (enable),
    .duty     (duty),
    .input1   (input1),
    .input2   (input2),
    .input3   (input3),
    .input4   (input4),
    .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase codes: 0 idle, 1 dead, 2 fwd, 3 rev, 4 turn left, 5 turn right.
  int         m_phase = 0, m_left = 0, m_target = 0, m_turn = 0, m_pcnt = 0;
  int         m_run [2];
  bit         m_db [2];
  bit         m_s1 [2];
  bit         m_s2 [2];
  logic [3:0] m_out = 4'b0000;

  function automatic logic [3:0] pattern_of(input int ph);
    case (ph)
      2:       return 4'b1001;
      3:       return 4'b0110;
      4:       return 4'b0101;
      5:       return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  initial begin
    m_run = '{0, 0};
    m_db  = '{0, 0};
    m_s1  = '{0, 0};
    m_s2  = '{0, 0};
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_phase = 0; m_left = 0; m_target = 0; m_turn = 0; m_pcnt = 0;
        m_out = 4'b0000;
        for (int i = 0; i < 2; i++) begin
          m_run[i] = 0; m_db[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
      end else begin
        // Direction sequencing uses the accepted sensor levels from before this edge.
        if (!enable) begin
          m_phase = 0;
        end else begin
          case (m_phase)
            0: begin m_phase = 1; m_target = 2; m_left = DT; end
            1: begin
              m_left--;
              if (m_left == 0) begin
                m_phase = m_target;
                m_left  = (m_target == 3) ? REVC : TRN;
              end
            end
            2: if (m_db[0] || m_db[1]) begin
              m_turn = m_db[0] ? 5 : 4;
              m_phase = 1; m_target = 3; m_left = DT;
            end
            3: begin
              m_left--;
              if (m_left == 0) begin m_phase = 1; m_target = m_turn; m_left = DT; end
            end
            default: begin
              m_left--;
              if (m_left == 0) begin m_phase = 1; m_target = 2; m_left = DT; end
            end
          endcase
        end
        m_pcnt = (m_pcnt + 1) % (1 << PW);
        m_out  = (m_pcnt < int'(duty)) ? pattern_of(m_phase) : 4'b0000;
        for (int i = 0; i < 2; i++) begin
          if (m_s2[i] != m_db[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin m_db[i] = m_s2[i]; m_run[i] = 0; end
          end else begin
            m_run[i] = 0;
          end
        end
        m_s2 = m_s1;
        m_s1[0] = senseA;
        m_s1[1] = senseB;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_on) begin
        chk("model_state", 32'(dbg_state), 32'(m_phase));
        chk("model_pins", 32'({input1, input2, input3, input4}), 32'(m_out));
        chk("pairA_exclusive", 32'(input1 & input2), 32'd0);
        chk("pairB_exclusive", 32'(input3 & input4), 32'd0);
      end
    end
  end

  // ---------------- timed vector table ----------------
  typedef struct {
    bit         en;
    logic [3:0] duty;
    bit         sa;
    bit         sb;
    int         wait_n;
    logic [2:0] st;
    logic [3:0] pat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit en, input int d, input bit sa, input bit sb,
                              input int w, input int st, input logic [3:0] pat);
    vec_t v;
    v.en = en; v.duty = 4'(d); v.sa = sa; v.sb = sb;
    v.wait_n = w; v.st = 3'(st); v.pat = pat;
    return v;
  endfunction

  initial begin
    logic [3:0] exp_out;
    int         ones;

    reset = 1'b1; enable = 1'b0; duty = '0; senseA = 1'b0; senseB = 1'b0;

    // startup (wait counts are rising edges since the previous row)
    tbl.push_back(mk(1, 15, 0, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 1, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 5, 2, 4'b1001));
    // left obstacle: debounce, DEAD, REV, DEAD, TURN_R, DEAD, FWD
    tbl.push_back(mk(1, 15, 1, 0, 6, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 1, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 1, 0, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 1, 0, 1, 3, 4'b0110));
    tbl.push_back(mk(1, 15, 1, 0, 9, 3, 4'b0110));
    tbl.push_back(mk(1, 15, 1, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 1, 5, 4'b1010));
    tbl.push_back(mk(1, 15, 0, 0, 7, 5, 4'b1010));
    tbl.push_back(mk(1, 15, 0, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 1, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 5, 2, 4'b1001));
    // 3-cycle glitch is rejected
    tbl.push_back(mk(1, 15, 1, 0, 3, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 10, 2, 4'b1001));
    // both sensors at once -> TURN_R
    tbl.push_back(mk(1, 15, 1, 1, 7, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 16, 5, 4'b1010));
    tbl.push_back(mk(1, 15, 0, 0, 8, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 3, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 4, 2, 4'b1001));
    // right only -> TURN_L
    tbl.push_back(mk(1, 15, 0, 1, 7, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 16, 4, 4'b0101));
    tbl.push_back(mk(1, 15, 0, 0, 11, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 4, 2, 4'b1001));
    // sensor still held when FWD returns: FWD for one cycle only
    tbl.push_back(mk(1, 15, 1, 0, 7, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 1, 0, 26, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 1, 0, 1, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 1, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 16, 5, 4'b1010));
    tbl.push_back(mk(1, 15, 0, 0, 11, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 4, 2, 4'b1001));
    // enable drop during REV, then re-enable
    tbl.push_back(mk(1, 15, 1, 0, 7, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 5, 3, 4'b0110));
    tbl.push_back(mk(0, 15, 0, 0, 1, 0, 4'b0000));
    tbl.push_back(mk(0, 15, 0, 0, 3, 0, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 1, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 2, 1, 4'b0000));
    tbl.push_back(mk(1, 15, 0, 0, 1, 2, 4'b1001));
    tbl.push_back(mk(1, 15, 0, 0, 5, 2, 4'b1001));

    // initial reset, then run into FWD
    repeat (2) @(negedge clock);
    reset = 1'b0;
    chk_on = 1'b1;
    enable = 1'b1; duty = 4'd15;
    repeat (10) @(negedge clock);

    // reset asserted between edges must clear outputs immediately
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(dbg_state), 32'd0);
    chk("async_reset_pins", 32'({input1, input2, input3, input4}), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (tbl[k]) begin
      enable = tbl[k].en; duty = tbl[k].duty;
      senseA = tbl[k].sa; senseB = tbl[k].sb;
      repeat (tbl[k].wait_n) @(negedge clock);
      exp_out = (m_pcnt < int'(tbl[k].duty)) ? tbl[k].pat : 4'b0000;
      chk($sformatf("vec%0d_state", k), 32'(dbg_state), 32'(tbl[k].st));
      chk($sformatf("vec%0d_pins", k), 32'({input1, input2, input3, input4}), 32'(exp_out));
    end

    // duty 0: never on while in FWD
    duty = 4'd0;
    repeat (20) begin
      @(negedge clock);
      chk("duty0_state", 32'(dbg_state), 32'd2);
      chk("duty0_pins", 32'({input1, input2, input3, input4}), 32'd0);
    end

    // duty 4: exactly 4 of every 16 cycles on
    duty = 4'd4;
    @(negedge clock);
    ones = 0;
    repeat (16) begin
      @(negedge clock);
      if ({input1, input2, input3, input4} == 4'b1001) ones++;
    end
    chk("duty4_on_count", 32'(ones), 32'd4);
    chk("duty4_state", 32'(dbg_state), 32'd2);

    // randomized stimulus, checked cycle by cycle against the model
    duty = 4'd12;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      if ($urandom_range(39, 0) == 0) senseA = ~senseA;
      if ($urandom_range(39, 0) == 0) senseB = ~senseB;
      if (enable) begin
        if ($urandom_range(299, 0) == 0) enable = 1'b0;
      end else if ($urandom_range(9, 0) == 0) begin
        enable = 1'b1;
      end
      if ($urandom_range(99, 0) == 0) duty = 4'($urandom_range(15, 0));
    end
    @(negedge clock);
    chk_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
